// File: rtl/exc_irq_ctrl_if.sv
// exc_irq_ctrl_if: core-side signal bundle between the LEGv8 datapath/decoder and the exception controller
interface exc_irq_ctrl_if #(
  parameter int N       = 64,
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_src;
  logic [NUM_IRQ-1:0] irq_en;
  logic [N-1:0]       PC;
  logic               Exc;
  logic [3:0]         EStatus;
  logic               ERet;
  logic [1:0]         sysreg_sel;
  logic               ExtIRQ;
  logic               ExcRedirect;
  logic [N-1:0]       ExcVector;
  logic               ERetRedirect;
  logic [N-1:0]       ELR;
  logic [N-1:0]       ESR;
  logic [N-1:0]       sysreg_data;
  logic               in_handler;
  modport master (
    output irq_src, irq_en, PC, Exc, EStatus, ERet, sysreg_sel,
    input  ExtIRQ, ExcRedirect, ExcVector, ERetRedirect, ELR, ESR, sysreg_data, in_handler
  );
  modport slave (
    input  irq_src, irq_en, PC, Exc, EStatus, ERet, sysreg_sel,
    output ExtIRQ, ExcRedirect, ExcVector, ERetRedirect, ELR, ESR, sysreg_data, in_handler
  );
endinterface

// File: rtl/exc_irq_ctrl.sv
// exc_irq_ctrl: ELR/ESR system registers, RUN/HANDLER tracking, IRQ latching and PC redirects for LEGv8
module exc_irq_ctrl #(
  parameter int             N           = 64,
  parameter int             NUM_IRQ     = 4,
  parameter logic [N-1:0]   VECTOR_ADDR = 64'h0000_0000_0000_00D8
) (
  input logic           clk,
  input logic           reset,
  exc_irq_ctrl_if.slave bus
);
  typedef enum logic {RUN, HANDLER} state_t;
  state_t             state_q, state_d;
  logic [N-1:0]       elr_q, elr_d;
  logic [8:0]         esr_q, esr_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d, prev_q, masked, clr;
  logic [2:0]         irq_id;
  logic               irq_cause;
  assign masked    = pend_q & bus.irq_en;
  assign irq_cause = bus.EStatus == 4'b0001;
  // lowest-numbered enabled pending line wins
  always_comb begin
    irq_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (masked[i]) irq_id = 3'(i);
  end
  // next-state: exception entry, double fault, ERET return and pending accumulation
  always_comb begin
    state_d = state_q;
    elr_d   = elr_q;
    esr_d   = esr_q;
    clr     = '0;
    if (bus.Exc) begin
      if (state_q == RUN) begin
        elr_d   = bus.PC;
        esr_d   = {2'b00, irq_cause ? irq_id : 3'b000, bus.EStatus};
        clr     = (irq_cause && |masked) ? NUM_IRQ'(1) << irq_id : '0;
        state_d = HANDLER;
      end else
        esr_d = {1'b1, esr_q[7:4], bus.EStatus};
    end else if (bus.ERet && state_q == HANDLER)
      state_d = RUN;
    pend_d = (pend_q & ~clr) | (bus.irq_src & ~prev_q);
  end
  // state registers, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      elr_q   <= '0;
      esr_q   <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      elr_q   <= elr_d;
      esr_q   <= esr_d;
      pend_q  <= pend_d;
      prev_q  <= bus.irq_src;
    end
  end
  assign bus.ExtIRQ       = state_q == RUN && |masked;
  assign bus.ExcRedirect  = bus.Exc & ~reset;
  assign bus.ERetRedirect = bus.ERet & (state_q == HANDLER) & ~bus.Exc & ~reset;
  assign bus.ExcVector    = VECTOR_ADDR;
  assign bus.ELR          = elr_q;
  assign bus.ESR          = N'(esr_q);
  assign bus.in_handler   = state_q == HANDLER;
  assign bus.sysreg_data  = bus.sysreg_sel == 2'b00 ? elr_q :
                            bus.sysreg_sel == 2'b01 ? N'(esr_q) :
                            bus.sysreg_sel == 2'b10 ? N'(pend_q) : '0;
endmodule
